pattern_checker: RTL and testbench
==================================

# pattern_checker

- Sink-side companion to the video pattern generator.
- Drives `VideoReady` and accepts one 24-bit pixel on every cycle `VideoValid` is high.
- Regenerates the expected 128x64 four-quadrant pattern and its 1 Hz colour inversion, compares each received pixel against it, and reports mismatches.
- Sits at the sink end of the generator link, in the bring-up bench and in hardware self-test.

## Interface
- `VISIBLE_WIDTH`, 800, pixels per line.
- `VISIBLE_HEIGHT`, 600, lines per frame.
- `FRAME_RATE`, 72, frames per inversion period.
- `Q1_color`, 24'h00CC00, top-left quadrant colour.
- `Q2_color`, 24'h00CCCC, top-right quadrant colour.
- `Q3_color`, 24'hFF9A26, bottom-left quadrant colour.
- `Q4_color`, 24'h9D26FF, bottom-right quadrant colour.
- `clock` in 1: single clock domain.
- `reset` in 1: synchronous, active-low (0 = reset). Must be applied together with the generator's reset.
- `enable` in 1: when 0, `VideoReady` is deasserted (backpressure).
- `VideoReady` out 1: registered request to the source.
- `VideoValid` in 1: a pixel is present this cycle.
- `Video` in 24: pixel data.
- `error` out 1: sticky; set on the first mismatch.
- `error_count` out 32: saturating mismatch count.
- `frame_done` out 1: one-cycle pulse after the last pixel of each frame is checked.
- `invert_state` out 1: the checker's current inversion phase.
- `err_x` out 10, `err_y` out 10, `err_data` out 24: first-mismatch capture (see Configuration).

## Operation
- **Ready:** `VideoReady <= enable` each cycle. Reset value is 0.
- **Beat:** a beat is any cycle with `VideoValid`=1. It is accepted even if `VideoReady` has since dropped, because the source asserts valid one cycle after ready.
- **Position counters:**
  - `x` advances on each beat and wraps from `VISIBLE_WIDTH-1` to 0.
  - `y` advances on each x-wrap and wraps from `VISIBLE_HEIGHT-1` to 0.
  - `frame` advances on each frame wrap and wraps from `FRAME_RATE-1` to 0.
  - All three reset to 0.
- **Inversion phase:** `inv` resets to 0 and toggles on the beat that ends frame `FRAME_RATE-1`.
- **Quadrant select:** h = `x[6]`, v = `y[5]`.
  - h=0, v=0 → Q1
  - h=1, v=0 → Q2
  - h=0, v=1 → Q3
  - h=1, v=1 → Q4
  - Selection is derived directly from the counters; there are no toggle FSMs. It must equal the generator's toggling behaviour, including the reset of h at line start and v at frame start.
- **Expected value:** `exp = inv ? Qn : ~Qn`. The first period (inv=0) therefore carries inverted colours.
- **Compare pipeline:**
  - Stage 1 registers `{beat, Video, exp, x, y}`.
  - Stage 2 asserts a mismatch when the stage-1 beat is set and data ≠ exp.
  - On a mismatch: `error <= 1` and `error_count <= error_count + 1`, saturating at 32'hFFFFFFFF.
- **Reset:** any reset, including mid-frame, clears counters, the pipeline, `inv`, `error`, `error_count`, the capture registers, and `frame_done`. All outputs are 0 during reset.

## Timing
- Beat at cycle N: `error` and `error_count` reflect it at cycle N+2.
- `frame_done` pulses at N+2 for the beat at (`VISIBLE_WIDTH-1`, `VISIBLE_HEIGHT-1`).
- `invert_state` changes at N+1 after the final beat of the period.
- Back-to-back beats on every cycle: full throughput, no stall.
- Gaps in `VideoValid`: counters hold and the pipeline bubbles (stage-1 beat = 0, no compare).
- `enable` falling at cycle M: `VideoReady` falls at M+1. One further beat may arrive at M+1 and is checked.
- A beat coinciding with saturation: the count stays at max and `error` stays 1.

## Configuration
- Macro: `PATTERN_CHECKER_CAPTURE_EN`.
- **Defined:**
  - On the first mismatch after reset (when `error` goes 0→1), latch `err_x`, `err_y`, `err_data` from stage 1.
  - The registers hold until reset; later mismatches do not update them.
- **Undefined:**
  - The capture registers are not built.
  - `err_x`, `err_y`, `err_data` are constant 0.
  - All other behaviour is identical.

## Test plan
- **Clean run:** connect the generator (default parameters), `enable`=1, run 2×72 frames.
  - Required: `error`=0, `error_count`=0.
  - Required: `invert_state` toggles exactly twice, and `frame_done` pulses 144 times.
- **Colour injection:** generator with Q1=24'h00CC01, one frame.
  - Required: `error_count`=129792 (416 Q1 columns × 312 Q1 rows).
  - Required with capture: `err_x`=0, `err_y`=0, `err_data`=24'hFF33FE.
- **Backpressure:** clean generator, `enable` toggling pseudo-randomly (~50%) for 3 frames.
  - Required: `error`=0, and `frame_done` count = 3.
- **Reset mid-frame:** assert `reset`=0 for 2 cycles at pixel (400,300) of frame 5 on both blocks, then release and run 1 frame.
  - Required: all outputs 0 during reset, then `error_count`=0 and `frame_done`=1.
- **Saturation:** force `error_count` to 32'hFFFFFFFE, inject 3 mismatching beats.
  - Required: `error_count`=32'hFFFFFFFF and `error`=1.
- **Single bad pixel:** corrupt only beat (127,63) of frame 0 to 24'h000000.
  - Required: `error_count`=1 at 2 cycles after that beat.
  - Required with capture: `err_x`=127, `err_y`=63.

Source files
------------

// File: rtl/pattern_checker.sv
// =============================================================================
// Module   : pattern_checker
// Purpose  : Sink-side checker for the four-quadrant video test pattern with
//            periodic colour inversion; counts and flags pixel mismatches.
//            Optional first-mismatch capture: PATTERN_CHECKER_CAPTURE_EN.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module pattern_checker #(
    parameter int          VISIBLE_WIDTH  = 800,
    parameter int          VISIBLE_HEIGHT = 600,
    parameter int          FRAME_RATE     = 72,
    parameter logic [23:0] Q1_color       = 24'h00CC00,
    parameter logic [23:0] Q2_color       = 24'h00CCCC,
    parameter logic [23:0] Q3_color       = 24'hFF9A26,
    parameter logic [23:0] Q4_color       = 24'h9D26FF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    output logic        VideoReady,
    input  logic        VideoValid,
    input  logic [23:0] Video,
    output logic        error,
    output logic [31:0] error_count,
    output logic        frame_done,
    output logic        invert_state,
    output logic [9:0]  err_x,
    output logic [9:0]  err_y,
    output logic [23:0] err_data
);

    localparam int              FW     = (FRAME_RATE > 1) ? $clog2(FRAME_RATE) : 1;
    localparam logic [9:0]      X_LAST = 10'(VISIBLE_WIDTH - 1);
    localparam logic [9:0]      Y_LAST = 10'(VISIBLE_HEIGHT - 1);
    localparam logic [FW-1:0]   F_LAST = FW'(FRAME_RATE - 1);

    logic          r_ready;
    logic [9:0]    r_x;
    logic [9:0]    r_y;
    logic [FW-1:0] r_frame;
    logic          r_inv;

    logic          w_beat;
    logic          w_x_last;
    logic          w_y_last;
    logic          w_f_last;
    logic          w_frame_end;
    logic          w_period_end;
    logic [23:0]   w_quad;
    logic [23:0]   w_exp;

    logic          r_s1_beat;
    logic          r_s1_last;
    logic [23:0]   r_s1_data;
    logic [23:0]   r_s1_exp;

    logic          w_mismatch;
    logic          r_error;
    logic [31:0]   r_error_count;
    logic          r_frame_done;

    // Valid alone defines a beat: the source may still deliver one pixel
    // after ready has dropped.
    assign w_beat       = VideoValid;
    assign w_x_last     = (r_x == X_LAST);
    assign w_y_last     = (r_y == Y_LAST);
    assign w_f_last     = (r_frame == F_LAST);
    assign w_frame_end  = w_beat & w_x_last & w_y_last;
    assign w_period_end = w_frame_end & w_f_last;

    // Counter bits reproduce the generator's 64-pixel / 32-line toggles,
    // which restart at line and frame start.
    always_comb begin
        w_quad = Q1_color;
        case ({r_y[5], r_x[6]})
            2'b00:   w_quad = Q1_color;
            2'b01:   w_quad = Q2_color;
            2'b10:   w_quad = Q3_color;
            default: w_quad = Q4_color;
        endcase
    end

    assign w_exp = r_inv ? w_quad : ~w_quad;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ready <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_frame <= '0;
            r_inv   <= 1'b0;
        end else begin
            r_ready <= enable;
            if (w_beat) begin
                r_x <= w_x_last ? 10'd0 : r_x + 10'd1;
                if (w_x_last) begin
                    r_y <= w_y_last ? 10'd0 : r_y + 10'd1;
                end
                if (w_frame_end) begin
                    r_frame <= w_f_last ? '0 : r_frame + FW'(1);
                end
                if (w_period_end) begin
                    r_inv <= ~r_inv;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_s1_beat <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_data <= '0;
            r_s1_exp  <= '0;
        end else begin
            r_s1_beat <= w_beat;
            r_s1_last <= w_frame_end;
            r_s1_data <= Video;
            r_s1_exp  <= w_exp;
        end
    end

    assign w_mismatch = r_s1_beat && (r_s1_data != r_s1_exp);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_error       <= 1'b0;
            r_error_count <= '0;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done <= r_s1_beat & r_s1_last;
            if (w_mismatch) begin
                r_error <= 1'b1;
                if (r_error_count != 32'hFFFF_FFFF) begin
                    r_error_count <= r_error_count + 32'd1;
                end
            end
        end
    end

    assign VideoReady   = r_ready;
    assign error        = r_error;
    assign error_count  = r_error_count;
    assign frame_done   = r_frame_done;
    assign invert_state = r_inv;

`ifdef PATTERN_CHECKER_CAPTURE_EN
    logic [9:0]  r_s1_x;
    logic [9:0]  r_s1_y;
    logic [9:0]  r_err_x;
    logic [9:0]  r_err_y;
    logic [23:0] r_err_data;

    // Only the first mismatch after reset is latched (error still 0).
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_err_x    <= '0;
            r_err_y    <= '0;
            r_err_data <= '0;
        end else begin
            r_s1_x <= r_x;
            r_s1_y <= r_y;
            if (w_mismatch && !r_error) begin
                r_err_x    <= r_s1_x;
                r_err_y    <= r_s1_y;
                r_err_data <= r_s1_data;
            end
        end
    end

    assign err_x    = r_err_x;
    assign err_y    = r_err_y;
    assign err_data = r_err_data;
`else
    assign err_x    = '0;
    assign err_y    = '0;
    assign err_data = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pattern_checker.sv
// =============================================================================
// Module   : tb_pattern_checker
// Purpose  : Self-checking bench for pattern_checker with a behavioural
//            toggle-style pattern source. Capture build: PATTERN_CHECKER_CAPTURE_EN.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_pattern_checker;

    localparam int W  = 130;
    localparam int H  = 66;
    localparam int FR = 2;
    localparam logic [23:0] Q1 = 24'h00CC00;
    localparam logic [23:0] Q2 = 24'h00CCCC;
    localparam logic [23:0] Q3 = 24'hFF9A26;
    localparam logic [23:0] Q4 = 24'h9D26FF;
`ifdef PATTERN_CHECKER_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        enable;
    logic        VideoReady;
    logic        VideoValid;
    logic [23:0] Video;
    logic        error;
    logic [31:0] error_count;
    logic        frame_done;
    logic        invert_state;
    logic [9:0]  err_x;
    logic [9:0]  err_y;
    logic [23:0] err_data;

    pattern_checker #(
        .VISIBLE_WIDTH (W),
        .VISIBLE_HEIGHT(H),
        .FRAME_RATE    (FR)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .VideoReady  (VideoReady),
        .VideoValid  (VideoValid),
        .Video       (Video),
        .error       (error),
        .error_count (error_count),
        .frame_done  (frame_done),
        .invert_state(invert_state),
        .err_x       (err_x),
        .err_y       (err_y),
        .err_data    (err_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    int   fd_cnt;
    int   inv_tog;
    logic inv_prev;

    int          g_x, g_y, g_frame, g_hcnt, g_vcnt, frames_sent;
    logic        g_h, g_v, g_inv, rdy_d;
    logic [23:0] q1_gen;
    bit          corrupt_en, bad_flag, period_flag;

    typedef struct {
        logic        valid;
        logic [23:0] data;
        logic        exp_err;
        logic [31:0] exp_cnt;
    } vec_t;
    vec_t tbl[8];

    function automatic logic [9:0] cap10(input int v);
        return CAP ? 10'(v) : 10'd0;
    endfunction

    function automatic logic [23:0] cap24(input logic [23:0] v);
        return CAP ? v : 24'd0;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        if (frame_done) fd_cnt++;
        if (invert_state !== inv_prev) inv_tog++;
        inv_prev = invert_state;
    endtask

    // Source model: valid follows ready by one cycle; quadrant flags toggle
    // every 64 pixels / 32 lines and restart at line / frame start.
    task automatic step_gen();
        logic [23:0] q;
        logic [23:0] px;
        bad_flag    = 1'b0;
        period_flag = 1'b0;
        VideoValid  = rdy_d;
        rdy_d       = VideoReady;
        if (VideoValid) begin
            case ({g_v, g_h})
                2'b00:   q = q1_gen;
                2'b01:   q = Q2;
                2'b10:   q = Q3;
                default: q = Q4;
            endcase
            px = g_inv ? q : ~q;
            if (corrupt_en && g_x == 127 && g_y == 63 && g_frame == 0) begin
                px       = 24'h000000;
                bad_flag = 1'b1;
            end
            Video = px;
            if (g_x == W - 1) begin
                g_x = 0; g_h = 1'b0; g_hcnt = 0;
                if (g_y == H - 1) begin
                    g_y = 0; g_v = 1'b0; g_vcnt = 0;
                    frames_sent++;
                    if (g_frame == FR - 1) begin
                        g_frame     = 0;
                        g_inv       = ~g_inv;
                        period_flag = 1'b1;
                    end else begin
                        g_frame++;
                    end
                end else begin
                    g_y++;
                    if (g_vcnt == 31) begin g_vcnt = 0; g_v = ~g_v; end
                    else g_vcnt++;
                end
            end else begin
                g_x++;
                if (g_hcnt == 63) begin g_hcnt = 0; g_h = ~g_h; end
                else g_hcnt++;
            end
        end else begin
            Video = 24'h0;
        end
    endtask

    task automatic gen_cycle();
        tick();
        step_gen();
    endtask

    task automatic do_reset();
        reset = 1'b0; VideoValid = 1'b0; Video = 24'h0; rdy_d = 1'b0;
        g_x = 0; g_y = 0; g_frame = 0; g_hcnt = 0; g_vcnt = 0; frames_sent = 0;
        g_h = 1'b0; g_v = 1'b0; g_inv = 1'b0;
        repeat (2) begin
            tick();
            check("rst_outs", {VideoReady, error, error_count, frame_done, invert_state,
                               err_x, err_y, err_data}, 96'd0);
        end
        reset = 1'b1;
        fd_cnt = 0; inv_tog = 0; inv_prev = 1'b0;
    endtask

    task automatic drain();
        tick();
        VideoValid = 1'b0;
        Video      = 24'h0;
        repeat (3) tick();
    endtask

    task automatic run_frames(input int n, input int budget, input string name, input bit rnd);
        int k = 0;
        while (frames_sent < n && k < budget) begin
            if (rnd) enable = 1'($urandom_range(0, 1));
            gen_cycle();
            k++;
        end
        check({name, "_timeout"}, 96'(frames_sent >= n), 96'd1);
        drain();
    endtask

    initial begin
        int k;
        reset = 1'b0; enable = 1'b1; VideoValid = 1'b0; Video = 24'h0;
        q1_gen = Q1; corrupt_en = 1'b0; bad_flag = 1'b0; period_flag = 1'b0;
        rdy_d = 1'b0; fd_cnt = 0; inv_tog = 0; inv_prev = 1'b0;

        tbl[0] = '{1'b1, 24'hFF33FF, 1'b0, 32'd0};
        tbl[1] = '{1'b0, 24'h000000, 1'b0, 32'd0};
        tbl[2] = '{1'b1, 24'hFF33FF, 1'b0, 32'd0};
        tbl[3] = '{1'b1, 24'h123456, 1'b1, 32'd1};
        tbl[4] = '{1'b1, 24'hFF33FF, 1'b1, 32'd1};
        tbl[5] = '{1'b0, 24'h123456, 1'b1, 32'd1};
        tbl[6] = '{1'b1, 24'h00CC00, 1'b1, 32'd2};
        tbl[7] = '{1'b1, 24'hFF33FF, 1'b1, 32'd2};

        // Reset values, ready behaviour and single-beat table
        do_reset();
        tick();
        check("ready_on", 96'(VideoReady), 96'd1);
        for (int i = 0; i < 8; i++) begin
            VideoValid = tbl[i].valid;
            Video      = tbl[i].data;
            tick();
            VideoValid = 1'b0;
            tick();
            check($sformatf("tbl%0d_err", i), 96'(error), 96'(tbl[i].exp_err));
            check($sformatf("tbl%0d_cnt", i), 96'(error_count), 96'(tbl[i].exp_cnt));
        end
        check("tbl_cap_x", 96'(err_x), 96'(cap10(2)));
        check("tbl_cap_data", 96'(err_data), 96'(cap24(24'h123456)));
        enable = 1'b0;
        tick();
        check("ready_off", 96'(VideoReady), 96'd0);
        enable = 1'b1;

        // Clean run over two inversion periods
        do_reset();
        k = 0;
        while (!period_flag && k < 20000) begin gen_cycle(); k++; end
        check("period_timeout", 96'(period_flag), 96'd1);
        check("inv_at_n", 96'(invert_state), 96'd0);
        gen_cycle();
        check("inv_at_n1", 96'(invert_state), 96'd1);
        check("fdone_at_n1", 96'(frame_done), 96'd0);
        gen_cycle();
        check("fdone_at_n2", 96'(frame_done), 96'd1);
        run_frames(2 * FR, 40000, "clean", 1'b0);
        check("clean_err", 96'(error), 96'd0);
        check("clean_cnt", 96'(error_count), 96'd0);
        check("clean_inv_toggles", 96'(inv_tog), 96'd2);
        check("clean_fdone", 96'(fd_cnt), 96'(2 * FR));
        check("clean_inv_final", 96'(invert_state), 96'd0);

        // Single corrupted pixel at (127,63)
        do_reset();
        corrupt_en = 1'b1;
        k = 0;
        do begin gen_cycle(); k++; end while (!bad_flag && k < 12000);
        corrupt_en = 1'b0;
        check("bad_timeout", 96'(bad_flag), 96'd1);
        gen_cycle();
        check("bad_cnt_n1", 96'(error_count), 96'd0);
        gen_cycle();
        check("bad_cnt_n2", 96'(error_count), 96'd1);
        check("bad_err", 96'(error), 96'd1);
        check("bad_cap_x", 96'(err_x), 96'(cap10(127)));
        check("bad_cap_y", 96'(err_y), 96'(cap10(63)));
        repeat (100) gen_cycle();
        check("bad_cnt_hold", 96'(error_count), 96'd1);

        // Q1 colour injection for one frame
        do_reset();
        q1_gen = 24'h00CC01;
        run_frames(1, 12000, "inject", 1'b0);
        q1_gen = Q1;
        check("inject_cnt", 96'(error_count), 96'd2244);
        check("inject_cap_x", 96'(err_x), 96'(cap10(0)));
        check("inject_cap_y", 96'(err_y), 96'(cap10(0)));
        check("inject_cap_data", 96'(err_data), 96'(cap24(24'hFF33FE)));

        // Pseudo-random backpressure
        do_reset();
        run_frames(1, 40000, "bp", 1'b1);
        enable = 1'b1;
        check("bp_err", 96'(error), 96'd0);
        check("bp_fdone", 96'(fd_cnt), 96'd1);

        // Reset in mid-frame after errors have accumulated
        do_reset();
        q1_gen = 24'h00CC01;
        k = 0;
        while (!(g_x == 65 && g_y == 33) && k < 12000) begin gen_cycle(); k++; end
        check("mid_pre_err", 96'(error), 96'd1);
        q1_gen = Q1;
        do_reset();
        run_frames(1, 12000, "mid", 1'b0);
        check("mid_cnt", 96'(error_count), 96'd0);
        check("mid_err", 96'(error), 96'd0);
        check("mid_fdone", 96'(fd_cnt), 96'd1);

        // Saturation of the mismatch counter
        do_reset();
        force dut.r_error_count = 32'hFFFF_FFFE;
        tick();
        release dut.r_error_count;
        VideoValid = 1'b1;
        Video      = 24'h000000;
        tick();
        tick();
        check("sat_first", 96'(error_count), 96'hFFFF_FFFF);
        tick();
        VideoValid = 1'b0;
        tick();
        tick();
        check("sat_final", 96'(error_count), 96'hFFFF_FFFF);
        check("sat_err", 96'(error), 96'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
